// File: rtl/uart_tx_pkg.sv
// Shared types and helpers for the UART transmit path.
// Data helpers are sized for the widest character any engine instance supports.
package uart_tx_pkg;

  localparam int unsigned MAX_DATA_W = 9;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_e;

  typedef enum logic [1:0] {
    STOP_1,
    STOP_1P5,
    STOP_2
  } stop_len_e;

  function automatic logic [3:0] clamp_len(input logic [3:0] cfg_data_bits,
                                           input int unsigned max_bits);
    logic [3:0] len;
    if (cfg_data_bits < 4'd5)
      len = 4'd5;
    else if (32'(cfg_data_bits) > max_bits)
      len = 4'(max_bits);
    else
      len = cfg_data_bits;
    return len;
  endfunction

  // Only bits below len contribute; stick parity forces the inverse of eps.
  function automatic logic parity_bit(input logic [MAX_DATA_W-1:0] data,
                                      input logic [3:0]            len,
                                      input logic                  eps,
                                      input logic                  stick);
    logic x;
    x = 1'b0;
    for (int i = 0; i < int'(MAX_DATA_W); i++)
      if (i < int'(len)) x = x ^ data[i];
    if (stick)
      return ~eps;
    return eps ? x : ~x;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Oversample tick down-counter: loads on bit entry, decrements on each tick,
// flags done on the tick that finds it at zero.
module uart_bit_timer #(
  parameter int unsigned W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_tick,
  output logic         o_done
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst)
      r_cnt <= '0;
    else if (i_load)
      r_cnt <= i_load_val;
    else if (i_tick && (r_cnt != '0))
      r_cnt <= r_cnt - W'(1);
  end

  assign o_done = i_tick & (r_cnt == '0);

endmodule

// File: rtl/uart_tx_gen.sv
// UART transmit engine: one character per valid/ready transfer, framed as
// start, 5..MAX_DATA_BITS data bits LSB first, optional parity, 1/1.5/2 stop.
//
// state  | meaning
// IDLE   | line high, ready for a character
// START  | start bit (low)
// DATA   | shifting data bits out, LSB first
// PARITY | parity bit
// STOP   | stop bit(s), high
module uart_tx_gen
  import uart_tx_pkg::*;
#(
  parameter int unsigned OVERSAMPLE    = 16,
  parameter int unsigned MAX_DATA_BITS = 9
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     baud_pulse,
  input  logic [3:0]               cfg_data_bits,
  input  logic                     cfg_pen,
  input  logic                     cfg_eps,
  input  logic                     cfg_stick,
  input  logic                     cfg_stb,
  input  logic                     set_break,
  input  logic                     s_valid,
  input  logic [MAX_DATA_BITS-1:0] s_data,
  output logic                     s_ready,
  output logic                     tx,
  output logic                     busy,
  output logic                     sreg_empty,
  output logic                     char_done
);

  localparam int unsigned TW = $clog2(2 * OVERSAMPLE);
  localparam logic [TW-1:0] LD_BIT = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] LD_1P5 = TW'((3 * OVERSAMPLE) / 2 - 1);
  localparam logic [TW-1:0] LD_2   = TW'(2 * OVERSAMPLE - 1);

  state_e                   r_state;
  state_e                   w_state_nxt;
  logic [MAX_DATA_BITS-1:0] r_shift;
  logic [3:0]               r_len;
  logic [3:0]               r_bit_cnt;
  logic                     r_pen;
  logic                     r_par;
  stop_len_e                r_stop_len;
  logic                     r_tx;
  logic                     r_char_done;

  logic                     w_xfer;
  logic                     w_timer_done;
  logic                     w_bit_end;
  logic                     w_load;
  logic [TW-1:0]            w_load_val;
  logic                     w_tx_bit;
  logic [3:0]               w_len;
  stop_len_e                w_stop_len;

  assign s_ready   = (r_state == IDLE) & ~rst;
  assign w_xfer    = s_valid & s_ready;
  assign w_len     = clamp_len(cfg_data_bits, MAX_DATA_BITS);
  assign w_bit_end = w_timer_done & (r_state != IDLE);
  assign w_load    = w_xfer | w_bit_end;

  always_comb begin
    w_stop_len = STOP_1;
    if (cfg_stb)
      w_stop_len = (w_len == 4'd5) ? STOP_1P5 : STOP_2;
  end

  uart_bit_timer #(
    .W(TW)
  ) u_bit_timer (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .i_tick     (baud_pulse),
    .o_done     (w_timer_done)
  );

  always_ff @(posedge clk) begin
    if (rst)
      r_state <= IDLE;
    else
      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (w_xfer) w_state_nxt = START;
      START:   if (w_bit_end) w_state_nxt = DATA;
      DATA:    if (w_bit_end && (r_bit_cnt == 4'd0)) w_state_nxt = r_pen ? PARITY : STOP;
      PARITY:  if (w_bit_end) w_state_nxt = STOP;
      STOP:    if (w_bit_end) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_tx_bit   = 1'b1;
    w_load_val = LD_BIT;
    unique case (r_state)
      START:   w_tx_bit = 1'b0;
      DATA:    w_tx_bit = r_shift[0];
      PARITY:  w_tx_bit = r_par;
      default: w_tx_bit = 1'b1;
    endcase
    if (w_state_nxt == STOP) begin
      unique case (r_stop_len)
        STOP_1P5: w_load_val = LD_1P5;
        STOP_2:   w_load_val = LD_2;
        default:  w_load_val = LD_BIT;
      endcase
    end
  end

  assign busy       = (r_state != IDLE);
  assign sreg_empty = !((r_state == START) || (r_state == DATA));

  // Character and framing are frozen at transfer; cfg may change mid-frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_shift    <= '0;
      r_len      <= 4'd5;
      r_bit_cnt  <= 4'd0;
      r_pen      <= 1'b0;
      r_par      <= 1'b0;
      r_stop_len <= STOP_1;
    end else if (w_xfer) begin
      r_shift    <= s_data;
      r_len      <= w_len;
      r_pen      <= cfg_pen;
      r_par      <= parity_bit(MAX_DATA_W'(s_data), w_len, cfg_eps, cfg_stick);
      r_stop_len <= w_stop_len;
    end else if (w_bit_end) begin
      if (r_state == START) begin
        r_bit_cnt <= r_len - 4'd1;
      end else if (r_state == DATA) begin
        r_shift <= r_shift >> 1;
        if (r_bit_cnt != 4'd0)
          r_bit_cnt <= r_bit_cnt - 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx        <= 1'b1;
      r_char_done <= 1'b0;
    end else begin
      r_tx        <= w_tx_bit & ~set_break;
      r_char_done <= w_bit_end & (r_state == STOP);
    end
  end

  assign tx        = r_tx;
  assign char_done = r_char_done;

endmodule

// File: tb/tb_uart_tx_gen.sv
// Scoreboard bench for uart_tx_gen: each transfer pushes the expected per-tick
// line levels of its frame; the monitor pops one entry per observed baud tick.
module tb_uart_tx_gen;

  localparam int OS  = 16;
  localparam int MDB = 9;

  logic           clk = 1'b0;
  logic           rst;
  logic           baud_pulse = 1'b0;
  logic [3:0]     cfg_data_bits;
  logic           cfg_pen;
  logic           cfg_eps;
  logic           cfg_stick;
  logic           cfg_stb;
  logic           set_break;
  logic           s_valid;
  logic [MDB-1:0] s_data;
  logic           s_ready;
  logic           tx;
  logic           busy;
  logic           sreg_empty;
  logic           char_done;

  typedef struct packed {
    logic lvl;
    logic sre;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_err = 0;
  int   baud_mode = 1;

  uart_tx_gen #(
    .OVERSAMPLE    (OS),
    .MAX_DATA_BITS (MDB)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .baud_pulse    (baud_pulse),
    .cfg_data_bits (cfg_data_bits),
    .cfg_pen       (cfg_pen),
    .cfg_eps       (cfg_eps),
    .cfg_stick     (cfg_stick),
    .cfg_stb       (cfg_stb),
    .set_break     (set_break),
    .s_valid       (s_valid),
    .s_data        (s_data),
    .s_ready       (s_ready),
    .tx            (tx),
    .busy          (busy),
    .sreg_empty    (sreg_empty),
    .char_done     (char_done)
  );

  always #5 clk = ~clk;

  // 0: no ticks, 1: tick every clk, 2: random ~1 in 4
  always @(negedge clk) begin
    case (baud_mode)
      0:       baud_pulse = 1'b0;
      1:       baud_pulse = 1'b1;
      default: baud_pulse = ($urandom_range(0, 3) == 0);
    endcase
  end

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_cfg(input logic [MDB-1:0] d, input logic [3:0] bits, input logic pen,
                         input logic eps, input logic stick, input logic stb);
    s_data        = d;
    cfg_data_bits = bits;
    cfg_pen       = pen;
    cfg_eps       = eps;
    cfg_stick     = stick;
    cfg_stb       = stb;
  endtask

  // Expected frame from the values on the pins at the transfer edge.
  task automatic push_frame();
    int   len;
    int   stop_t;
    logic x;
    logic p;
    if (cfg_data_bits < 4'd5)      len = 5;
    else if (cfg_data_bits > MDB)  len = MDB;
    else                           len = int'(cfg_data_bits);
    x = 1'b0;
    for (int i = 0; i < len; i++) x = x ^ s_data[i];
    if (cfg_stick)    p = ~cfg_eps;
    else if (cfg_eps) p = x;
    else              p = ~x;
    if (!cfg_stb)       stop_t = OS;
    else if (len == 5)  stop_t = 3 * OS / 2;
    else                stop_t = 2 * OS;
    repeat (OS) exp_q.push_back('{1'b0, 1'b0});
    for (int i = 0; i < len; i++)
      repeat (OS) exp_q.push_back('{s_data[i], 1'b0});
    if (cfg_pen) repeat (OS) exp_q.push_back('{p, 1'b1});
    repeat (stop_t) exp_q.push_back('{1'b1, 1'b1});
  endtask

  // Called at a negedge; returns 1ns after the transfer edge.
  task automatic xfer(input logic keep);
    int w = 0;
    s_valid = 1'b1;
    while (!s_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk_eq("s_ready", s_ready, 1);
    @(posedge clk);
    push_frame();
    #1 s_valid = keep;
  endtask

  task automatic run_frame(input int brk_on, input int brk_off, input int rst_at, input int wake_at);
    logic lvl_prev;
    logic ticked;
    logic brk;
    int   k = 0;
    lvl_prev = exp_q[0].lvl;
    while (exp_q.size() != 0) begin
      k++;
      @(posedge clk);
      ticked = baud_pulse;
      brk    = set_break;
      if (rst) begin
        @(negedge clk);
        chk_eq("rst_tx", tx, 1);
        chk_eq("rst_busy", busy, 0);
        chk_eq("rst_sreg_empty", sreg_empty, 1);
        chk_eq("rst_char_done", char_done, 0);
        rst       = 1'b0;
        set_break = 1'b0;
        exp_q.delete();
        return;
      end
      @(negedge clk);
      chk_eq("tx", tx, lvl_prev & ~brk);
      if (ticked) void'(exp_q.pop_front());
      chk_eq("char_done", char_done, exp_q.size() == 0);
      chk_eq("busy", busy, exp_q.size() != 0);
      chk_eq("sreg_empty", sreg_empty, (exp_q.size() == 0) ? 1'b1 : exp_q[0].sre);
      if (exp_q.size() != 0) lvl_prev = exp_q[0].lvl;
      set_break = (k >= brk_on) && (k < brk_off);
      rst       = (k == rst_at);
      if (k == wake_at) baud_mode = 1;
      if (k > 4000) begin
        chk_eq("timeout", k, 0);
        exp_q.delete();
      end
    end
  endtask

  initial begin
    logic seen;
    rst = 1'b1;
    s_valid = 1'b0;
    set_break = 1'b0;
    set_cfg(9'h000, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    chk_eq("reset_tx", tx, 1);
    chk_eq("reset_busy", busy, 0);
    chk_eq("reset_sreg_empty", sreg_empty, 1);
    chk_eq("reset_char_done", char_done, 0);
    chk_eq("reset_s_ready", s_ready, 0);
    rst = 1'b0;
    @(negedge clk);
    chk_eq("idle_s_ready", s_ready, 1);

    // 8N1, 8E2, 8O2, stick parity both ways
    set_cfg(9'h013, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0); xfer(1'b0); run_frame(-1, -1, -1, -1);
    set_cfg(9'h013, 4'd8, 1'b1, 1'b1, 1'b0, 1'b1); xfer(1'b0); run_frame(-1, -1, -1, -1);
    set_cfg(9'h013, 4'd8, 1'b1, 1'b0, 1'b0, 1'b1); xfer(1'b0); run_frame(-1, -1, -1, -1);
    set_cfg(9'h013, 4'd8, 1'b1, 1'b1, 1'b1, 1'b0); xfer(1'b0); run_frame(-1, -1, -1, -1);
    set_cfg(9'h013, 4'd8, 1'b1, 1'b0, 1'b1, 1'b0); xfer(1'b0); run_frame(-1, -1, -1, -1);

    // 5-bit characters with 1.5 stop bits; upper data bits must not leak into parity
    set_cfg(9'h1F3, 4'd5, 1'b0, 1'b0, 1'b0, 1'b1); xfer(1'b0); run_frame(-1, -1, -1, -1);
    set_cfg(9'h0F3, 4'd5, 1'b1, 1'b1, 1'b0, 1'b1); xfer(1'b0); run_frame(-1, -1, -1, -1);

    // back-to-back with cfg changed under the first frame
    set_cfg(9'h055, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0); xfer(1'b1);
    @(negedge clk);
    set_cfg(9'h1A6, 4'd7, 1'b1, 1'b0, 1'b0, 1'b1);
    run_frame(-1, -1, -1, -1);
    chk_eq("b2b_s_ready", s_ready, 1);
    xfer(1'b0); run_frame(-1, -1, -1, -1);

    // break pulse in the middle of the data bits
    set_cfg(9'h0FF, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0); xfer(1'b0); run_frame(40, 50, -1, -1);

    // reset during the parity bit, then a clean frame
    set_cfg(9'h013, 4'd8, 1'b1, 1'b1, 1'b0, 1'b0); xfer(1'b0); run_frame(-1, -1, 150, -1);
    seen = 1'b0;
    repeat (30) begin
      @(negedge clk);
      seen = seen | char_done;
    end
    chk_eq("no_char_done_after_rst", seen, 0);
    set_cfg(9'h0A5, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0); xfer(1'b0); run_frame(-1, -1, -1, -1);

    // no baud ticks: transfer still accepted, frame frozen until ticks resume
    baud_mode = 0;
    set_cfg(9'h03C, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0); xfer(1'b0); run_frame(-1, -1, -1, 30);

    // sparse random ticks with random framing, including out-of-range lengths
    baud_mode = 2;
    for (int n = 0; n < 6; n++) begin
      set_cfg(MDB'($urandom_range(0, 511)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      xfer(1'b0);
      run_frame(-1, -1, -1, -1);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
